// File: rtl/s_regfile_sb.sv
// s_regfile_sb: scalar register file with reservation scoreboard and NWR write-back channels; SREG_BYPASS_EN adds same-cycle forwarding.
// Reads are combinational, writes and busy changes land one edge later; issue is held (o_iss_ready low) while a used or reserved register is busy.
module s_regfile_sb #(
    parameter int WIDTH    = 64,
    parameter int DEPTH    = 8,
    parameter int LOGDEPTH = 3,
    parameter int NWR      = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [LOGDEPTH-1:0]       i_j_addr,
    input  logic [LOGDEPTH-1:0]       i_k_addr,
    input  logic [LOGDEPTH-1:0]       i_i_addr,
    output logic [WIDTH-1:0]          o_j_data,
    output logic [WIDTH-1:0]          o_k_data,
    output logic [WIDTH-1:0]          o_i_data,
    input  logic [LOGDEPTH-1:0]       i_ex_addr,
    output logic [WIDTH-1:0]          o_ex_data,
    input  logic                      i_iss_valid,
    input  logic                      i_iss_use_j,
    input  logic                      i_iss_use_k,
    input  logic                      i_iss_use_i,
    input  logic                      i_iss_rsv,
    output logic                      o_iss_ready,
    input  logic [NWR-1:0]            i_wr_en,
    input  logic [NWR*LOGDEPTH-1:0]   i_wr_addr,
    input  logic [NWR*WIDTH-1:0]      i_wr_data,
    output logic [DEPTH-1:0]          o_busy,
    output logic                      o_s0_pos,
    output logic                      o_s0_neg,
    output logic                      o_s0_zero,
    output logic                      o_s0_nzero,
    output logic                      o_err_unrsv,
    output logic                      o_err_collide
);

    logic [WIDTH-1:0]    data_q [DEPTH];
    logic [DEPTH-1:0]    busy_q, busy_d;
    logic                err_unrsv_q, err_unrsv_d;
    logic                err_collide_q, err_collide_d;
    logic [DEPTH-1:0]    wr_hit;
    logic [WIDTH-1:0]    wr_val [DEPTH];
    logic [WIDTH:0]      j_fwd, k_fwd, i_fwd;
    logic                j_busy, k_busy, i_busy;
    logic                iss_fire;

    // Merge channels per register; later channels overwrite earlier ones so the highest wins.
    always_comb begin
        logic [LOGDEPTH-1:0] a;
        wr_hit        = '0;
        err_unrsv_d   = err_unrsv_q;
        err_collide_d = err_collide_q;
        a             = '0;
        for (int r = 0; r < DEPTH; r++) wr_val[r] = '0;
        for (int n = 0; n < NWR; n++) begin
            if (i_wr_en[n]) begin
                a = i_wr_addr[n*LOGDEPTH +: LOGDEPTH];
                if (wr_hit[a])  err_collide_d = 1'b1;
                if (!busy_q[a]) err_unrsv_d   = 1'b1;
                wr_hit[a] = 1'b1;
                wr_val[a] = i_wr_data[n*WIDTH +: WIDTH];
            end
        end
    end

`ifdef SREG_BYPASS_EN
    function automatic logic [WIDTH:0] fwd(input logic [LOGDEPTH-1:0]     a,
                                           input logic [NWR-1:0]          en,
                                           input logic [NWR*LOGDEPTH-1:0] wa,
                                           input logic [NWR*WIDTH-1:0]    wd);
        fwd = '0;
        for (int n = 0; n < NWR; n++) begin
            if (en[n] && wa[n*LOGDEPTH +: LOGDEPTH] == a) fwd = {1'b1, wd[n*WIDTH +: WIDTH]};
        end
    endfunction

    assign j_fwd = fwd(i_j_addr, i_wr_en, i_wr_addr, i_wr_data);
    assign k_fwd = fwd(i_k_addr, i_wr_en, i_wr_addr, i_wr_data);
    assign i_fwd = fwd(i_i_addr, i_wr_en, i_wr_addr, i_wr_data);
`else
    assign j_fwd = '0;
    assign k_fwd = '0;
    assign i_fwd = '0;
`endif

    assign o_j_data  = j_fwd[WIDTH]       ? j_fwd[WIDTH-1:0] :
                       (i_j_addr == '0)   ? '0 : data_q[i_j_addr];
    assign o_k_data  = k_fwd[WIDTH]       ? k_fwd[WIDTH-1:0] :
                       (i_k_addr == '0)   ? {1'b1, {(WIDTH-1){1'b0}}} : data_q[i_k_addr];
    assign o_i_data  = i_fwd[WIDTH]       ? i_fwd[WIDTH-1:0] : data_q[i_i_addr];
    assign o_ex_data = data_q[i_ex_addr];

    // A register being forwarded this cycle no longer blocks issue.
    assign j_busy = busy_q[i_j_addr] & ~j_fwd[WIDTH];
    assign k_busy = busy_q[i_k_addr] & ~k_fwd[WIDTH];
    assign i_busy = busy_q[i_i_addr] & ~i_fwd[WIDTH];

    assign o_iss_ready = !((i_iss_use_j && j_busy) ||
                           (i_iss_use_k && k_busy) ||
                           ((i_iss_use_i || i_iss_rsv) && i_busy));
    assign iss_fire    = i_iss_valid && o_iss_ready && i_iss_rsv;

    always_comb begin
        busy_d = busy_q & ~wr_hit;
        if (iss_fire) busy_d[i_i_addr] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int r = 0; r < DEPTH; r++) data_q[r] <= '0;
            busy_q        <= '0;
            err_unrsv_q   <= 1'b0;
            err_collide_q <= 1'b0;
        end else begin
            for (int r = 0; r < DEPTH; r++) begin
                if (wr_hit[r]) data_q[r] <= wr_val[r];
            end
            busy_q        <= busy_d;
            err_unrsv_q   <= err_unrsv_d;
            err_collide_q <= err_collide_d;
        end
    end

    assign o_busy        = busy_q;
    assign o_s0_neg      = data_q[0][WIDTH-1];
    assign o_s0_pos      = ~data_q[0][WIDTH-1];
    assign o_s0_zero     = (data_q[0] == '0);
    assign o_s0_nzero    = (data_q[0] != '0);
    assign o_err_unrsv   = err_unrsv_q;
    assign o_err_collide = err_collide_q;

endmodule

// File: doc/s_regfile_sb.md
# s_regfile_sb

Parametrised scalar register file with an integrated reservation scoreboard. It sits between instruction issue and the scalar functional units: it supplies j/k/i operands, holds issue until source and destination registers are free, and accepts results from NWR independent functional-unit return channels. It also keeps the S0 branch-condition flags and provides a side read port for exchange-package dumping.

## Interface
- WIDTH, 64, register width in bits; S0 flags use bit WIDTH-1 as the sign bit.
- DEPTH, 8, number of registers.
- LOGDEPTH, 3, address width; must equal clog2(DEPTH).
- NWR, 2, number of functional-unit write-back channels; 1..4.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous and active-high. One clock; reset is synchronous and active-high.
- i_j_addr, i_k_addr, i_i_addr  in  LOGDEPTH each  operand read addresses.
- o_j_data, o_k_data, o_i_data  out  WIDTH each  operand read data.
- i_ex_addr  in  LOGDEPTH  exchange side-read address.
- o_ex_data  out  WIDTH  exchange side-read data; never bypassed.
- i_iss_valid  in  1  an instruction is presented for issue.
- i_iss_use_j, i_iss_use_k, i_iss_use_i  in  1 each  the instruction reads that operand.
- i_iss_rsv  in  1  the instruction writes S[i_i_addr] and must reserve it.
- o_iss_ready  out  1  no hazard; issue completes when i_iss_valid && o_iss_ready.
- i_wr_en  in  NWR  per-channel write strobe.
- i_wr_addr  in  NWR*LOGDEPTH  packed per-channel address; channel n uses bits [n*LOGDEPTH +: LOGDEPTH].
- i_wr_data  in  NWR*WIDTH  packed per-channel data.
- o_busy  out  DEPTH  reservation bit per register.
- o_s0_pos, o_s0_neg, o_s0_zero, o_s0_nzero  out  1 each  S0 condition flags.
- o_err_unrsv  out  1  sticky: a channel wrote a register that was not reserved.
- o_err_collide  out  1  sticky: two or more channels wrote the same address in the same cycle.

## Operation
- Reset: all registers 0, o_busy 0, both error flags 0. This gives o_s0_pos=1, o_s0_zero=1, o_s0_neg=0, o_s0_nzero=0, and o_iss_ready=1.
- Read conventions:
  - j port at address 0 returns 0.
  - k port at address 0 returns 1<<(WIDTH-1).
  - i port and ex port return S0 unmodified.
- Hazard: o_iss_ready = !(use_j&&busy[j] || use_k&&busy[k] || (use_i||rsv)&&busy[i]). The j/k/i checks apply whatever special value the j/k ports return for address 0.
  - o_iss_ready is purely combinational from current addresses, use bits and o_busy.
  - o_iss_ready does not depend on i_iss_valid.
- Reservation: on an issue with i_iss_rsv=1, busy[i_i_addr] sets at the next edge.
- Write-back: for each channel with i_wr_en[n], at the clock edge:
  - data[addr] <= data, and busy[addr] clears.
  - If busy[addr] was 0, o_err_unrsv sets.
- Same-address collision between channels: the highest-numbered channel's data wins and o_err_collide sets. Distinct addresses all write in the same cycle.
- A write-back and a new reservation to the same address in the same cycle: the data is written and busy ends set, because reservation has priority over clear.
- S0 flags decode the stored S0 only; they never see bypassed data.
- Error flags clear only on rst.

## Timing
- Reads: combinational from the addresses and stored state, plus the bypass path when configured.
- Write to readback: a written value is visible at the array output on the cycle after the write edge.
- Busy: set and clear each take effect one edge after the qualifying cycle.
  - A waiting instruction sees o_iss_ready rise in the cycle after its source's write-back.
  - With bypass, the waiting instruction can issue in the write-back cycle itself, because forwarding also clears the hazard for that register.
- Reset mid-operation: any pending reservations are dropped and in-flight writes presented during the rst cycle are ignored.

## Configuration
- SREG_BYPASS_EN defined:
  - j, k and i ports forward same-cycle write data when any i_wr_en[n] matches the read address, taking the highest-numbered matching channel.
  - The matching register is treated as not busy for the o_iss_ready computation in that cycle.
  - Forwarding overrides the address-0 constants on the j and k ports.
  - The ex port and S0 flags never bypass.
- SREG_BYPASS_EN undefined: reads return stored data only, and hazards use o_busy as stored.

## Test plan
- Reset, then read j=0, k=0, i=0 → 0, 0x8000000000000000, 0; flags pos=1, zero=1; o_busy=0; o_iss_ready=1.
- Issue with rsv to S3, then present use_j=1, j=3 → o_iss_ready=0 until channel 1 writes S3=0x1234; then with bypass o_iss_ready=1 in the write cycle with o_j_data=0x1234, and without bypass o_iss_ready=1 one cycle later.
- Channels 0 and 1 both write S5 in the same cycle with 0xAA and 0xBB → S5=0xBB, o_err_collide=1.
- Write S2 when busy[2]=0 → data written, o_err_unrsv=1, flag holds until rst.
- Same cycle: write-back to S4 and issue rsv S4 → S4 updated, busy[4]=1.
- Write S0=0xFFFF_FFFF_FFFF_FFFF → next cycle neg=1, nzero=1; assert rst with busy bits set → all busy clear and the error flags clear.
